demux_dispatcher: RTL and testbench
===================================

# demux_dispatcher

Round-robin dispatch controller that sequences a 1-to-4 demultiplexer. It accepts a valid/ready input stream and routes each word to one of four output channels. Each channel has a one-word holding register and its own valid/ready handshake. The block sits between a single producer and four consumer lanes, and it exports the demux select of the most recent dispatch.

## Interface
- WIDTH, 8, data width of the input word and of each output channel
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk
- in_data  input  WIDTH  input word
- in_valid  input  1  producer presents in_data
- in_ready  output  1  dispatcher can accept this cycle; combinational
- y0, y1, y2, y3  output  WIDTH each  channel holding registers
- out_valid  output  4  bit i set = channel i holds an undelivered word
- out_ready  input  4  bit i = consumer i accepts this cycle
- sel  output  2  channel index of the most recent accepted word
- occupancy  output  3  number of set out_valid bits, range 0..4
- chan_en  input  4  per-channel dispatch enable; exists only with DEMUX_DISPATCH_MASK_EN

## Operation
- Internal 2-bit round-robin pointer ptr.
- Channel i is eligible when out_valid[i]=0 and chan_en[i]=1.
- in_ready = 1 when any channel is eligible. in_ready does not depend on in_valid.
- Accept: in_valid & in_ready on a rising edge.
  - Target = first eligible channel in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - y_target <= in_data; out_valid[target] <= 1; sel <= target; ptr <= target+1 (mod 4); 3+1 wraps to 0.
- Drain: out_valid[i] & out_ready[i] clears out_valid[i] on the next edge. y_i holds its value after the drain.
- A slot freed by a drain becomes eligible only in the following cycle. There is no same-cycle drain-and-reload on the same channel.
- Simultaneous accept and drain on different channels both take effect.
- occupancy = popcount(out_valid), registered to match out_valid. Accept and drain in the same cycle leave occupancy unchanged.
- out_valid[i] and y_i must not change while out_valid[i]=1 and out_ready[i]=0.
- With no accept, ptr and sel hold.

## Timing
- Reset values: out_valid=0000, y0..y3=0, sel=00, ptr=0, occupancy=0. in_ready=1 in the first cycle after reset, given any enabled channel.
- Latency: a word accepted at edge N has out_valid set after edge N, so it is visible in cycle N+1.
- Throughput: one word per cycle while eligible channels exist.
- Full: all four out_valid set gives in_ready=0, and in_valid is ignored.
- Reset asserted mid-operation: all held words are discarded and all state returns to reset values on that edge, regardless of in_valid or out_ready.

## Configuration
- DEMUX_DISPATCH_MASK_EN defined:
  - chan_en port is present and gates eligibility.
  - A word already held in a channel that becomes disabled still drains normally.
  - chan_en=0000 forces in_ready=0.
- Not defined:
  - chan_en port is absent and all channels are treated as enabled.
  - Behaviour is otherwise identical.

## Test plan
- Reset, then out_ready=0000 and four accepts of AA, BB, CC, DD -> y0..y3=AA, BB, CC, DD; sel sequence 0,1,2,3; occupancy reaches 4; in_ready=0; a fifth in_valid is not accepted.
- Full, then out_ready=0010 for one cycle -> out_valid=1101 the next cycle; next accept of 55 lands in y1 (ptr=0 skips busy 0, picks 1); sel=1.
- Continuous in_valid with out_ready=1111 -> one accept per cycle; targets rotate 0,1,2,3,0; occupancy stays ≤2; data is preserved per channel.
- Backpressure: out_valid[2]=1 with out_ready[2]=0 for 5 cycles -> y2 and out_valid[2] are stable across all 5 cycles.
- Mask build: chan_en=0101, out_ready=0000, three accepts attempted -> words land in y0 then y2; third attempt sees in_ready=0; chan_en=0000 -> in_ready=0.
- Reset asserted with occupancy=3 and in_valid=1 -> next cycle out_valid=0000, sel=0, occupancy=0, no word accepted.

Source files
------------

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: round-robin dispatcher feeding four one-word output channels (optional chan_en mask via DEMUX_DISPATCH_MASK_EN)
module demux_dispatcher #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel,
    output logic [2:0]       occupancy
`ifdef DEMUX_DISPATCH_MASK_EN
    ,
    input  logic [3:0]       chan_en
`endif
);
    logic [WIDTH-1:0] r_y [4];
    logic [3:0]       r_valid;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [2:0]       r_occ;
    logic [3:0]       w_en;
    logic [3:0]       w_elig;
    logic [7:0]       w_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_tgt;
    logic             w_acc;
    logic [3:0]       w_valid_nxt;
    logic [2:0]       w_occ_nxt;

`ifdef DEMUX_DISPATCH_MASK_EN
    assign w_en = chan_en;
`else
    assign w_en = 4'hF;
`endif
    assign w_elig    = ~r_valid & w_en;
    assign in_ready  = |w_elig;
    assign w_acc     = in_valid & in_ready;
    assign w_dbl     = {w_elig, w_elig} >> r_ptr;
    assign w_rot     = w_dbl[3:0];
    assign y0        = r_y[0];
    assign y1        = r_y[1];
    assign y2        = r_y[2];
    assign y3        = r_y[3];
    assign out_valid = r_valid;
    assign sel       = r_sel;
    assign occupancy = r_occ;

    // pick the first eligible channel at or after ptr; compute next valid mask and its popcount
    always_comb begin
        w_tgt = r_ptr;
        for (int k = 3; k >= 0; k--)
            w_tgt = w_rot[k] ? r_ptr + 2'(k) : w_tgt;
        w_valid_nxt = (r_valid & ~(r_valid & out_ready)) | (w_acc ? 4'b0001 << w_tgt : 4'b0000);
        w_occ_nxt = '0;
        for (int i = 0; i < 4; i++)
            w_occ_nxt = w_occ_nxt + 3'(w_valid_nxt[i]);
    end

    // register channel state; accepted word loads the target and advances the pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                r_y[i] <= '0;
            r_valid <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            if (w_acc) begin
                r_y[w_tgt] <= in_data;
                r_sel      <= w_tgt;
                r_ptr      <= w_tgt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed self-checking bench for demux_dispatcher
module tb_demux_dispatcher;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y0, y1, y2, y3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] sel;
    logic [2:0] occupancy;
    logic [3:0] chan_en;
    int         errors;
    int         checks;

    demux_dispatcher #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .y0(y0),
        .y1(y1),
        .y2(y2),
        .y3(y3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel(sel),
        .occupancy(occupancy)
`ifdef DEMUX_DISPATCH_MASK_EN
        ,
        .chan_en(chan_en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'h0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 4'h0;
        chan_en = 4'hF;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if ({y0, y1, y2, y3} !== 32'h0) begin errors++; $display("FAIL reset_y got %h exp 00000000", {y0, y1, y2, y3}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fill();
        logic [7:0] d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = d[i];
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", i, in_ready); end
            step();
            checks++; if (sel !== 2'(i)) begin errors++; $display("FAIL fill_sel%0d got %0d exp %0d", i, sel, i); end
            checks++; if (occupancy !== 3'(i + 1)) begin errors++; $display("FAIL fill_occ%0d got %0d exp %0d", i, occupancy, i + 1); end
        end
        checks++; if ({y0, y1, y2, y3} !== 32'hAABBCCDD) begin errors++; $display("FAIL fill_data got %h exp AABBCCDD", {y0, y1, y2, y3}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        checks++; if ({y0, y1, y2, y3} !== 32'hAABBCCDD) begin errors++; $display("FAIL full_ignore_data got %h exp AABBCCDD", {y0, y1, y2, y3}); end
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL full_ignore_sel got %0d exp 3", sel); end
        checks++; if (out_valid !== 4'hF) begin errors++; $display("FAIL full_valid got %b exp 1111", out_valid); end
    endtask

    task automatic test_drain_reload();
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b1101) begin errors++; $display("FAIL drain_valid got %b exp 1101", out_valid); end
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL drain_occ got %0d exp 3", occupancy); end
        checks++; if (y1 !== 8'hBB) begin errors++; $display("FAIL drain_hold_y1 got %h exp BB", y1); end
        in_valid = 1'b1;
        in_data = 8'h55;
        step();
        in_valid = 1'b0;
        checks++; if (y1 !== 8'h55) begin errors++; $display("FAIL reload_y1 got %h exp 55", y1); end
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL reload_sel got %0d exp 1", sel); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL reload_occ got %0d exp 4", occupancy); end
        checks++; if (y0 !== 8'hAA) begin errors++; $display("FAIL reload_y0 got %h exp AA", y0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 4'hF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h10 + 8'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, in_ready); end
            step();
            checks++; if (sel !== 2'(i % 4)) begin errors++; $display("FAIL b2b_sel%0d got %0d exp %0d", i, sel, i % 4); end
            checks++; if (out_valid !== 4'(1 << (i % 4))) begin errors++; $display("FAIL b2b_valid%0d got %b exp %b", i, out_valid, 4'(1 << (i % 4))); end
            checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL b2b_occ%0d got %0d exp 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL b2b_empty got %b exp 0000", out_valid); end
        checks++; if ({y0, y1, y2, y3} !== 32'h14111213) begin errors++; $display("FAIL b2b_data got %h exp 14111213", {y0, y1, y2, y3}); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'h0;
        in_valid = 1'b1;
        in_data = 8'h61;
        step();
        in_data = 8'h62;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL bp_setup got %b exp 0110", out_valid); end
        out_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (y2 !== 8'h62 || out_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got y2=%h v=%b exp y2=62 v=1", i, y2, out_valid[2]); end
        end
        out_ready = 4'b0100;
        step();
        out_ready = 4'h0;
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL bp_release got %b exp 0000", out_valid); end
    endtask

`ifdef DEMUX_DISPATCH_MASK_EN
    task automatic test_mask();
        do_reset();
        chan_en = 4'b0101;
        in_valid = 1'b1;
        in_data = 8'hA1;
        step();
        in_data = 8'hA2;
        step();
        in_data = 8'hA3;
        checks++; if ({y0, y2, out_valid} !== 20'hA1A2_5) begin errors++; $display("FAIL mask_route got %h exp A1A25", {y0, y2, out_valid}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mask_third_ready got %b exp 0", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL mask_third_sel got %0d exp 2", sel); end
        chan_en = 4'b0000;
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL mask_drain got %b exp 0000", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mask_none_ready got %b exp 0", in_ready); end
        chan_en = 4'hF;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            step();
        end
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL rmid_pre_occ got %0d exp 3", occupancy); end
        rst_n = 1'b0;
        out_ready = 4'hF;
        in_data = 8'hFF;
        step();
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rmid_valid got %b exp 0000", out_valid); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rmid_sel got %0d exp 0", sel); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rmid_occ got %0d exp 0", occupancy); end
        checks++; if ({y0, y1, y2, y3} !== 32'h0) begin errors++; $display("FAIL rmid_y got %h exp 00000000", {y0, y1, y2, y3}); end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 4'h0;
        step();
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rmid_after got %b exp 0000", out_valid); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill();
        test_drain_reload();
        test_back_to_back();
        test_backpressure();
`ifdef DEMUX_DISPATCH_MASK_EN
        test_mask();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
